data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Multicycle data-memory responder: the memory end of the control unit's
//  DataMemRW interface. Accepts one load/store request at a time from the
//  CPU datapath/FSM. Returns read data or write completion after a fixed
//  programmable wait. Lets the control FSM hold its MEM state until resp_valid.
// PARAMETERS
//  DEPTH    64  number of 32-bit words stored (index = addr[31:2])
//  LATENCY  2   wait cycles between accept and response (0..15)
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   asynchronous, active-low reset (0 = reset)
//  req_valid  in   1   request present this cycle
//  DataMemRW  in   1   0 = read (load), 1 = write (store); sampled at accept
//  addr       in   32  byte address; must be word aligned
//  wdata      in   32  store data; sampled at accept
//  req_ready  out  1   responder idle, can accept (= state==IDLE)
//  resp_valid out  1   one-cycle response strobe
//  rdata      out  32  load data, valid while resp_valid
//  err        out  1   misaligned or out-of-range access, valid with resp_valid
// BEHAVIOUR
//  - Reset (reset==0, async): state=IDLE, req_ready=1, resp_valid=0, rdata=0,
//    err=0, wait counter=0. Memory array is NOT cleared; contents survive reset.
//  - FSM states: IDLE -> WAIT -> RESP -> IDLE. With LATENCY==0, WAIT is skipped.
//  - Accept: at a rising edge with req_valid & req_ready. Latch addr, wdata and
//    DataMemRW. Load counter=LATENCY. Go to WAIT (or RESP if LATENCY==0).
//  - WAIT: the counter decrements each edge. When counter==1 at an edge, go to
//    RESP. The edge that enters RESP is the commit edge.
//  - Commit edge:
//      - Write: mem[idx] <= wdata.
//      - Read: rdata <= mem[idx].
//      - err <= (addr[1:0]!=0) | (idx>=DEPTH).
//      - If err: no write and rdata <= 0.
//      - Write with no error: rdata <= 0.
//  - RESP lasts exactly one cycle with resp_valid=1. Next edge returns to IDLE.
//    At that edge resp_valid, err and rdata clear to 0.
//  - Timing: accept at edge N gives resp_valid high for cycle N+LATENCY+1 ..
//    N+LATENCY+2.
//  - Minimum request spacing is LATENCY+2 cycles.
//  - req_ready=0 in WAIT and RESP. req_valid in those states is ignored.
//    It is neither queued nor sampled.
//  - Request fields may change freely after accept; only latched copies are used.
//  - Read-after-write to the same word returns the new data. The write commits
//    before any later request can be accepted.
//  - Reset mid-operation: abandon the request immediately. A write whose commit
//    edge has not occurred is lost. No resp_valid is produced for it.
//  - Counter is 4 bits wide. LATENCY>15 is a configuration error (elaboration
//    check required).
// TESTING
//  1. Reset, LATENCY=2: write 0xDEADBEEF to addr 0x10, accept at edge N.
//     -> req_ready=0 for 3 cycles, resp_valid high cycle N+3, err=0, rdata=0.
//  2. Read addr 0x10 after test 1 -> resp_valid 3 cycles after accept,
//     rdata=0xDEADBEEF, err=0.
//  3. Read addr 0x12 (misaligned), then write addr 0x100 (idx 64 >= DEPTH).
//     -> err=1, rdata=0 for both; a later read of word 0 is unchanged.
//  4. Hold req_valid=1 continuously with changing addr.
//     -> exactly one accept per LATENCY+2 cycles; only addresses present at
//        accept edges are serviced.
//  5. Assert reset one cycle after accepting a write of 0x12345678 to 0x20.
//     -> no resp_valid, outputs return to reset values, a later read of 0x20
//        returns the old value.
//  6. LATENCY=0 build: back-to-back write/read of 0x04 with 0xA5A5A5A5.
//     -> resp_valid the cycle after each accept; the read returns 0xA5A5A5A5.

Source files
------------

// File: rtl/data_mem_responder.sv
// Multicycle data-memory responder: accepts one load/store at a time and answers
// with a single-cycle resp_valid strobe a fixed LATENCY cycles after acceptance.
module data_mem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        DataMemRW,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        err
);
    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  LAT     = LATENCY[3:0];
    localparam logic [31:0] DEPTH_W = DEPTH;

    generate
        if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
            $error("data_mem_responder: LATENCY must be in 0..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        rw_reg;
    logic [31:0] addr_reg, wdata_reg;
    logic [31:0] rdata_reg;
    logic        err_reg;
    logic [31:0] mem [DEPTH];

    logic        accept;
    logic        commit;
    logic        cur_rw;
    logic [31:0] cur_addr, cur_wdata;
    logic [29:0] cur_idx;
    logic [AW-1:0] cur_ptr;
    logic        cur_err;

    assign accept = req_valid && (state_reg == IDLE);

    // With LATENCY==0 the commit edge is the accept edge, so the live request is used.
    assign cur_rw    = (state_reg == IDLE) ? DataMemRW : rw_reg;
    assign cur_addr  = (state_reg == IDLE) ? addr      : addr_reg;
    assign cur_wdata = (state_reg == IDLE) ? wdata     : wdata_reg;
    assign cur_idx   = cur_addr[31:2];
    assign cur_ptr   = cur_idx[AW-1:0];
    assign cur_err   = (cur_addr[1:0] != 2'b00) || ({2'b00, cur_idx} >= DEPTH_W);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        commit     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (LAT == 4'd0) begin
                        state_next = RESP;
                        commit     = 1'b1;
                        cnt_next   = 4'd0;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = LAT;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd1) begin
                    state_next = RESP;
                    commit     = 1'b1;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // The array write lives here so that a clock edge seen while reset is low never stores.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            rw_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                rw_reg    <= DataMemRW;
                addr_reg  <= addr;
                wdata_reg <= wdata;
            end
            if (commit) begin
                err_reg <= cur_err;
                if (cur_err || cur_rw) begin
                    rdata_reg <= '0;
                end else begin
                    rdata_reg <= mem[cur_ptr];
                end
                if (!cur_err && cur_rw) begin
                    mem[cur_ptr] <= cur_wdata;
                end
            end else if (state_reg == RESP) begin
                rdata_reg <= '0;
                err_reg   <= 1'b0;
            end
        end
    end

    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == RESP);
    assign rdata      = rdata_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one LATENCY=2 and one LATENCY=0 instance checked
// every cycle against a timeline model, plus directed literal expectations.
`timescale 1ns/1ps
module tb_data_mem_responder;
    localparam int DEPTH = 64;
    localparam int LAT_A = 2;
    localparam int LAT_B = 0;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  rv    = '0;
    logic [1:0]  rw    = '0;
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [1:0]  ready, vld, eo;
    logic [31:0] rd [2];

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT_A)) u_dut_a (
        .clk(clk), .reset(reset), .req_valid(rv[0]), .DataMemRW(rw[0]),
        .addr(ad[0]), .wdata(wd[0]), .req_ready(ready[0]), .resp_valid(vld[0]),
        .rdata(rd[0]), .err(eo[0])
    );

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT_B)) u_dut_b (
        .clk(clk), .reset(reset), .req_valid(rv[1]), .DataMemRW(rw[1]),
        .addr(ad[1]), .wdata(wd[1]), .req_ready(ready[1]), .resp_valid(vld[1]),
        .rdata(rd[1]), .err(eo[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT_A : LAT_B;
    endfunction

    task automatic check1(input string name, input int d, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: actual %b required %b", name, d, act, exp);
        end
    endtask

    task automatic check32(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: actual %h required %h", name, d, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int d, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: actual %0d required %0d", name, d, act, exp);
        end
    endtask

    // Timeline model: a request accepted at edge a commits at edge a+L,
    // shows its response until edge a+L+1, and the responder is free again after that.
    bit          m_busy  [2];
    int          m_acc   [2];
    bit          m_rw    [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wd    [2];
    logic [31:0] m_mem   [2][DEPTH];
    bit          m_known [2][DEPTH];
    bit          m_err   [2];
    logic [31:0] m_rd    [2];
    bit          m_rdk   [2];

    task automatic model_commit(input int d);
        int idx;
        idx      = int'(m_addr[d] >> 2);
        m_err[d] = (m_addr[d][1:0] != 2'b00) || (idx >= DEPTH);
        m_rd[d]  = '0;
        m_rdk[d] = 1'b1;
        if (!m_err[d]) begin
            if (m_rw[d]) begin
                m_mem[d][idx]   = m_wd[d];
                m_known[d][idx] = 1'b1;
            end else begin
                m_rd[d]  = m_mem[d][idx];
                m_rdk[d] = m_known[d][idx];
            end
        end
    endtask

    task automatic model_edge(input int d);
        if (!reset) begin
            m_busy[d] = 1'b0;
        end else if (m_busy[d]) begin
            if (edge_n == m_acc[d] + lat_of(d) + 1) m_busy[d] = 1'b0;
            else if (edge_n == m_acc[d] + lat_of(d)) model_commit(d);
        end else if (rv[d]) begin
            m_busy[d] = 1'b1;
            m_acc[d]  = edge_n;
            m_rw[d]   = rw[d];
            m_addr[d] = ad[d];
            m_wd[d]   = wd[d];
            if (lat_of(d) == 0) model_commit(d);
        end
    endtask

    always @(posedge clk) begin
        edge_n++;
        for (int d = 0; d < 2; d++) model_edge(d);
    end

    always @(negedge clk) begin
        logic        e_rdy, e_vld, e_err, rdk;
        logic [31:0] e_rd;
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                e_rdy = 1'b1; e_vld = 1'b0; e_err = 1'b0; e_rd = '0; rdk = 1'b1;
            end else begin
                e_rdy = !m_busy[d];
                e_vld = m_busy[d] && (edge_n == m_acc[d] + lat_of(d));
                e_err = e_vld && m_err[d];
                e_rd  = e_vld ? m_rd[d] : 32'h0;
                rdk   = !e_vld || m_rdk[d];
            end
            check1("model req_ready", d, ready[d], e_rdy);
            check1("model resp_valid", d, vld[d], e_vld);
            check1("model err", d, eo[d], e_err);
            if (rdk) check32("model rdata", d, rd[d], e_rd);
        end
    end

    task automatic do_req(input int d, input logic w, input logic [31:0] a, input logic [31:0] data,
                          output logic [31:0] r_data, output logic r_err, output int r_lat, output int r_busy);
        bit got;
        @(negedge clk);
        rv[d] = 1'b1; rw[d] = w; ad[d] = a; wd[d] = data;
        @(posedge clk);
        @(negedge clk);
        rv[d] = 1'b0; rw[d] = 1'($urandom_range(0, 1)); ad[d] = $urandom; wd[d] = $urandom;
        got = 1'b0; r_busy = 0; r_lat = -1; r_data = '0; r_err = 1'b0;
        for (int k = 0; k < 16 && !got; k++) begin
            if (k > 0) @(negedge clk);
            if (!ready[d]) r_busy++;
            if (vld[d]) begin
                got = 1'b1; r_lat = k; r_data = rd[d]; r_err = eo[d];
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL resp timeout dut%0d addr %h: no resp_valid within 16 cycles", d, a);
        end
    endtask

    task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] data,
                        input logic [31:0] exp_rd, input logic exp_err, input string tag);
        logic [31:0] r_data;
        logic        r_err;
        int          r_lat, r_busy;
        do_req(d, w, a, data, r_data, r_err, r_lat, r_busy);
        check32({tag, " rdata"}, d, r_data, exp_rd);
        check1({tag, " err"}, d, r_err, exp_err);
        check_int({tag, " latency"}, d, r_lat, lat_of(d));
        check_int({tag, " busy cycles"}, d, r_busy, lat_of(d) + 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          nresp;
        logic [31:0] got4 [$];
        logic [31:0] exp4 [3];
        exp4[0] = 32'hC0DE0010; exp4[1] = 32'hC0DE0014; exp4[2] = 32'hC0DE0018;
        for (int d = 0; d < 2; d++) begin
            ad[d] = '0; wd[d] = '0;
        end

        #2;
        check1("reset req_ready", 0, ready[0], 1'b1);
        check1("reset resp_valid", 0, vld[0], 1'b0);
        check32("reset rdata", 0, rd[0], 32'h0);
        check1("reset err", 0, eo[0], 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1 reset = 1'b1;

        // Store then load back through the LATENCY=2 instance.
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "t1 write 0x10");
        xfer(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "t2 read 0x10");

        // Misaligned and out-of-range accesses must not disturb word 0.
        xfer(0, 1'b1, 32'h00, 32'h0BADF00D, 32'h0, 1'b0, "t3 write 0x0");
        xfer(0, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, "t3 read 0x12");
        xfer(0, 1'b1, 32'h100, 32'hFFFFFFFF, 32'h0, 1'b1, "t3 write 0x100");
        xfer(0, 1'b0, 32'h00, 32'h0, 32'h0BADF00D, 1'b0, "t3 read 0x0");

        // req_valid held high with a new address every cycle.
        for (int k = 16; k < 28; k++)
            xfer(0, 1'b1, 32'(4 * k), 32'hC0DE0000 + 32'(k), 32'h0, 1'b0, "t4 prefill");
        nresp = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (j > 0 && vld[0]) begin nresp++; got4.push_back(rd[0]); end
            rv[0] = 1'b1; rw[0] = 1'b0; ad[0] = 32'h40 + 32'(4 * j);
        end
        @(negedge clk);
        if (vld[0]) begin nresp++; got4.push_back(rd[0]); end
        rv[0] = 1'b0;
        check_int("t4 response count", 0, nresp, 3);
        for (int i = 0; i < got4.size() && i < 3; i++)
            check32("t4 serviced data", 0, got4[i], exp4[i]);

        // Reset one cycle after accepting a write: the write must be lost.
        xfer(0, 1'b1, 32'h20, 32'h11112222, 32'h0, 1'b0, "t5 old value");
        @(negedge clk);
        rv[0] = 1'b1; rw[0] = 1'b1; ad[0] = 32'h20; wd[0] = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        rv[0] = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check1("t5 async req_ready", 0, ready[0], 1'b1);
        check1("t5 async resp_valid", 0, vld[0], 1'b0);
        check32("t5 async rdata", 0, rd[0], 32'h0);
        repeat (3) begin
            @(negedge clk);
            check1("t5 no resp in reset", 0, vld[0], 1'b0);
        end
        #1 reset = 1'b1;
        xfer(0, 1'b0, 32'h20, 32'h0, 32'h11112222, 1'b0, "t5 read 0x20");

        // LATENCY=0 instance, back-to-back store and load.
        xfer(1, 1'b1, 32'h04, 32'hA5A5A5A5, 32'h0, 1'b0, "t6 write 0x04");
        xfer(1, 1'b0, 32'h04, 32'h0, 32'hA5A5A5A5, 1'b0, "t6 read 0x04");
        xfer(1, 1'b0, 32'h07, 32'h0, 32'h0, 1'b1, "t6 read 0x07");

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
